// File: rtl/gbuf_access_arbiter_if.sv
// Requester-side and buffer-side signal bundle for gbuf_access_arbiter.
// The slave modport is the arbiter; the master modport is the surrounding system.
interface gbuf_access_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_we;
  logic [NUM_REQ-1:0]    req_lock;
  logic [NUM_REQ*32-1:0] req_addr;
  logic [NUM_REQ*16-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [15:0]           rsp_data;
  logic [NUM_REQ-1:0]    rsp_err;
  logic                  gbuf_ce;
  logic                  gbuf_we;
  logic [31:0]           gbuf_addr;
  logic [15:0]           gbuf_wdata;
  logic [15:0]           gbuf_rdata;

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata, gbuf_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
           gbuf_ce, gbuf_we, gbuf_addr, gbuf_wdata
  );

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata, gbuf_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_err,
           gbuf_ce, gbuf_we, gbuf_addr, gbuf_wdata
  );
endinterface

// File: rtl/gbuf_access_arbiter.sv
// Round-robin arbiter with burst locking in front of the single-port global buffer.
// Optional macro GBUF_ARB_PRIO0_EN gives requester 0 strict priority and burst pre-emption.
module gbuf_access_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int DEPTH     = 1024,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  gbuf_access_arbiter_if.slave bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {ARB, LOCKED} state_t;

  state_t             state_q;
  logic [PW-1:0]      rr_ptr_q;
  logic [PW-1:0]      owner_q;
  logic [7:0]         burst_cnt_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [NUM_REQ-1:0] rsp_err_q;

  logic [PW-1:0]      win;
  logic               win_vld;
  logic [PW-1:0]      cand;
  logic [PW-1:0]      rr_ptr_d;
  logic [NUM_REQ-1:0] gnt;
  logic [31:0]        sel_addr;
  logic [15:0]        sel_wdata;
  logic               sel_we;
  logic               sel_lock;
  logic               in_range;

  // Winner selection depends only on registered state and current requests.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    if (!rst) begin
      if (state_q == LOCKED) begin
        win     = owner_q;
        win_vld = bus.req_valid[owner_q];
      end else begin
`ifdef GBUF_ARB_PRIO0_EN
        if (bus.req_valid[0]) begin
          win     = '0;
          win_vld = 1'b1;
        end
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
          cand = PW'((int'(rr_ptr_q) + k) % NUM_REQ);
`ifdef GBUF_ARB_PRIO0_EN
          if (!win_vld && bus.req_valid[cand] && (cand != '0)) begin
`else
          if (!win_vld && bus.req_valid[cand]) begin
`endif
            win     = cand;
            win_vld = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (win_vld) gnt[win] = 1'b1;
  end

  assign sel_addr  = bus.req_addr[32*int'(win) +: 32];
  assign sel_wdata = bus.req_wdata[16*int'(win) +: 16];
  assign sel_we    = bus.req_we[win];
  assign sel_lock  = bus.req_lock[win];
  assign in_range  = (sel_addr < 32'(DEPTH));

  // In priority mode requester 0 never consumes a round-robin slot.
  always_comb begin
`ifdef GBUF_ARB_PRIO0_EN
    if (win == '0)                    rr_ptr_d = rr_ptr_q;
    else if (win == PW'(NUM_REQ - 1)) rr_ptr_d = PW'(1);
    else                              rr_ptr_d = win + PW'(1);
`else
    if (win == PW'(NUM_REQ - 1)) rr_ptr_d = '0;
    else                         rr_ptr_d = win + PW'(1);
`endif
  end

  assign bus.req_ready  = gnt;
  assign bus.gbuf_ce    = win_vld & in_range;
  assign bus.gbuf_we    = win_vld & sel_we;
  assign bus.gbuf_addr  = win_vld ? sel_addr  : 32'd0;
  assign bus.gbuf_wdata = win_vld ? sel_wdata : 16'd0;
  assign bus.rsp_valid  = rst ? '0 : rsp_valid_q;
  assign bus.rsp_err    = rst ? '0 : rsp_err_q;
  assign bus.rsp_data   = (!rst && (rsp_valid_q != '0)) ? bus.gbuf_rdata : 16'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= 8'd0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
    end else begin
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      if (win_vld) begin
        if (!in_range)    rsp_err_q   <= gnt;
        else if (!sel_we) rsp_valid_q <= gnt;
      end
      case (state_q)
        ARB: begin
          if (win_vld) begin
            rr_ptr_q <= rr_ptr_d;
            if (sel_lock && (MAX_BURST > 1)) begin
              state_q     <= LOCKED;
              owner_q     <= win;
              burst_cnt_q <= 8'd1;
            end
          end
        end
        LOCKED: begin
          // rr_ptr was advanced past the owner when the burst started.
          if (win_vld) begin
            if (sel_lock) begin
              burst_cnt_q <= burst_cnt_q + 8'd1;
              if ((burst_cnt_q + 8'd1) == 8'(MAX_BURST)) state_q <= ARB;
            end else begin
              state_q <= ARB;
            end
          end
`ifdef GBUF_ARB_PRIO0_EN
          if (bus.req_valid[0] && (owner_q != '0)) state_q <= ARB;
`endif
        end
        default: state_q <= ARB;
      endcase
    end
  end
endmodule

// File: tb/tb_gbuf_access_arbiter.sv
// Randomized bench with a behavioural arbiter/buffer model, plus directed literal checks.
module tb_gbuf_access_arbiter;
  localparam int N     = 3;
  localparam int DEPTH = 1024;
  localparam int MB    = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gbuf_access_arbiter_if #(.NUM_REQ(N)) bus();

  gbuf_access_arbiter #(.NUM_REQ(N), .DEPTH(DEPTH), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_val(int a);
    return 16'(a * 37) ^ 16'hA5C3;
  endfunction

  // Buffer device: one-cycle registered read, driven only by the DUT strobes.
  logic [15:0] gmem [DEPTH];
  bit          gwr  [DEPTH];
  always @(posedge clk) begin
    if (bus.gbuf_ce) begin
      if (bus.gbuf_we) begin
        gmem[bus.gbuf_addr[9:0]] <= bus.gbuf_wdata;
        gwr[bus.gbuf_addr[9:0]]  <= 1'b1;
      end else begin
        bus.gbuf_rdata <= gwr[bus.gbuf_addr[9:0]] ? gmem[bus.gbuf_addr[9:0]]
                                                  : init_val(int'(bus.gbuf_addr[9:0]));
      end
    end
  end

  // Reference model state.
  bit          m_locked = 1'b0;
  int          m_owner  = 0;
  int          m_cnt    = 0;
  int          m_rr     = 0;
  logic [N-1:0] m_prd   = '0;
  logic [N-1:0] m_perr  = '0;
  logic [15:0] m_pdata  = '0;
  logic [15:0] ref_mem [DEPTH];
  bit          ref_wr  [DEPTH];

  function automatic int pick();
    if (m_locked) return bus.req_valid[m_owner] ? m_owner : -1;
`ifdef GBUF_ARB_PRIO0_EN
    if (bus.req_valid[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_rr + k) % N;
`ifdef GBUF_ARB_PRIO0_EN
      if (c == 0) continue;
`endif
      if (bus.req_valid[c]) return c;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int          w;
    logic [31:0] a;
    bit          inr;
    logic [N-1:0] er;
    if (rst) begin
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_ce", bus.gbuf_ce, 0);
      chk("rst_we", bus.gbuf_we, 0);
      chk("rst_addr", bus.gbuf_addr, 0);
      chk("rst_wdata", bus.gbuf_wdata, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_err", bus.rsp_err, 0);
      m_locked = 1'b0; m_rr = 0; m_cnt = 0; m_owner = 0;
      m_prd = '0; m_perr = '0;
    end else begin
      chk("rsp_valid", bus.rsp_valid, m_prd);
      chk("rsp_err", bus.rsp_err, m_perr);
      if (m_prd != '0) chk("rsp_data", bus.rsp_data, m_pdata);
      w  = pick();
      er = '0;
      if (w >= 0) er[w] = 1'b1;
      chk("ready", bus.req_ready, er);
      a   = (w >= 0) ? bus.req_addr[32*w +: 32] : 32'd0;
      inr = (w >= 0) && (a < DEPTH);
      chk("gbuf_ce", bus.gbuf_ce, inr);
      if (inr) begin
        chk("gbuf_addr", bus.gbuf_addr, a);
        chk("gbuf_we", bus.gbuf_we, bus.req_we[w]);
        if (bus.req_we[w]) chk("gbuf_wdata", bus.gbuf_wdata, bus.req_wdata[16*w +: 16]);
      end
      m_prd = '0; m_perr = '0;
      if (w >= 0) begin
        if (!inr) m_perr[w] = 1'b1;
        else if (!bus.req_we[w]) begin
          m_prd[w] = 1'b1;
          m_pdata  = ref_wr[a[9:0]] ? ref_mem[a[9:0]] : init_val(int'(a[9:0]));
        end else begin
          ref_mem[a[9:0]] = bus.req_wdata[16*w +: 16];
          ref_wr[a[9:0]]  = 1'b1;
        end
        if (!m_locked) begin
`ifdef GBUF_ARB_PRIO0_EN
          if (w != 0) m_rr = (w == N - 1) ? 1 : w + 1;
`else
          m_rr = (w + 1) % N;
`endif
          if (bus.req_lock[w] && MB > 1) begin
            m_locked = 1'b1; m_owner = w; m_cnt = 1;
          end
        end else if (bus.req_lock[w]) begin
          m_cnt++;
          if (m_cnt == MB) m_locked = 1'b0;
        end else begin
          m_locked = 1'b0;
        end
      end
`ifdef GBUF_ARB_PRIO0_EN
      if (m_locked && bus.req_valid[0] && m_owner != 0) m_locked = 1'b0;
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_lock  = '0;
  endtask

  task automatic drive(int i, bit we, bit lock, logic [31:0] a, logic [15:0] d);
    bus.req_valid[i]          = 1'b1;
    bus.req_we[i]             = we;
    bus.req_lock[i]           = lock;
    bus.req_addr[32*i +: 32]  = a;
    bus.req_wdata[16*i +: 16] = d;
  endtask

  logic [2:0] rr_exp [6];

  initial begin
    int r;
    rst = 1'b1;
    idle_all();
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < N; i++) drive(i, 1'b0, 1'b0, 32'(10 + i), 16'd0);

    repeat (3) begin
      cyc();
      @(negedge clk);
      chk("reset_ready", bus.req_ready, 0);
      chk("reset_ce", bus.gbuf_ce, 0);
    end
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", bus.req_ready, 3'b001);
    chk("post_reset_ce", bus.gbuf_ce, 1);

`ifdef GBUF_ARB_PRIO0_EN
    rr_exp = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`else
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif
    chk("rr_grant0", bus.req_ready, rr_exp[0]);
    for (int k = 1; k < 6; k++) begin
      cyc();
      @(negedge clk);
      chk("rr_grant", bus.req_ready, rr_exp[k]);
    end

    cyc(); idle_all(); drive(1, 1'b1, 1'b0, 32'd5, 16'hBEEF);
    @(negedge clk);
    chk("wr_ready", bus.req_ready, 3'b010);
    cyc(); drive(1, 1'b0, 1'b0, 32'd5, 16'h0000);
    @(negedge clk);
    chk("rd_ready", bus.req_ready, 3'b010);
    cyc(); idle_all();
    @(negedge clk);
    chk("raw_rsp_valid", bus.rsp_valid, 3'b010);
    chk("raw_rsp_data", bus.rsp_data, 16'hBEEF);

`ifndef GBUF_ARB_PRIO0_EN
    cyc(); idle_all(); drive(2, 1'b0, 1'b1, 32'd20, 16'd0); drive(0, 1'b0, 1'b0, 32'd21, 16'd0);
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      if (k < 16) chk("burst_grant", bus.req_ready, 3'b100);
      else        chk("burst_release", bus.req_ready, 3'b001);
      cyc();
    end
    idle_all(); drive(2, 1'b0, 1'b0, 32'd22, 16'd0);
    @(negedge clk);
    chk("unlock_grant", bus.req_ready, 3'b100);
`endif

    cyc(); idle_all(); drive(0, 1'b0, 1'b0, 32'd1024, 16'd0);
    @(negedge clk);
    chk("oor_ready", bus.req_ready, 3'b001);
    chk("oor_ce", bus.gbuf_ce, 0);
    cyc(); idle_all();
    @(negedge clk);
    chk("oor_err", bus.rsp_err, 3'b001);
    chk("oor_rsp_valid", bus.rsp_valid, 0);

`ifdef GBUF_ARB_PRIO0_EN
    cyc(); drive(1, 1'b0, 1'b1, 32'd3, 16'd0);
    @(negedge clk); chk("prio_beat1", bus.req_ready, 3'b010);
    cyc();
    @(negedge clk); chk("prio_beat2", bus.req_ready, 3'b010);
    cyc(); drive(0, 1'b0, 1'b0, 32'd4, 16'd0);
    @(negedge clk); chk("prio_beat3", bus.req_ready, 3'b010);
    cyc();
    @(negedge clk); chk("prio_preempt", bus.req_ready, 3'b001);
    cyc(); idle_all();
`endif

    for (int n = 0; n < 3000; n++) begin
      cyc();
      for (int i = 0; i < N; i++) begin
        bus.req_valid[i] = ($urandom_range(0, 99) < 60);
        bus.req_we[i]    = ($urandom_range(0, 2) == 0);
        bus.req_lock[i]  = ($urandom_range(0, 3) == 0);
        r = int'($urandom_range(0, 19));
        if (r == 0)      bus.req_addr[32*i +: 32] = 32'(DEPTH + int'($urandom_range(0, 100)));
        else if (r == 1) bus.req_addr[32*i +: 32] = $urandom;
        else             bus.req_addr[32*i +: 32] = 32'($urandom_range(0, 15));
        bus.req_wdata[16*i +: 16] = 16'($urandom);
      end
      rst = ($urandom_range(0, 199) == 0);
    end

    cyc(); idle_all(); rst = 1'b0;
    repeat (3) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
